// File: rtl/seg_pkg.sv
// Shared types and constants for the six-digit 7-segment scan controller.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DIG_W      = 3;
  localparam int unsigned BIN_W      = 6;
  localparam int unsigned BCD_W      = 8;
  localparam int unsigned SEG_W      = 7;

  typedef enum logic [2:0] {
    SNAP,
    CONV_S,
    CONV_M,
    CONV_H,
    SCAN
  } state_e;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} patterns; element [n] is the glyph for digit n.
  localparam logic [9:0][SEG_W-1:0] SEG_LUT = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bus between the scan controller, the timekeeping counters, the shared converter and the display pins.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic             en;
  logic             blank_lz;
  logic [BIN_W-1:0] hours;
  logic [BIN_W-1:0] mins;
  logic [BIN_W-1:0] secs;
  logic [BIN_W-1:0] conv_bin;
  logic [BCD_W-1:0] conv_bcd;
  logic [NUM_DIGITS-1:0] an;
  logic [SEG_W-1:0] seg;
  logic             frame_done;

  modport slave (
    input  en, blank_lz, hours, mins, secs, conv_bcd,
    output conv_bin, an, seg, frame_done
  );

  modport master (
    output en, blank_lz, hours, mins, secs, conv_bcd,
    input  conv_bin, an, seg, frame_done
  );

endinterface

// File: rtl/seg7_decode.sv
// BCD nibble to active-low 7-segment pattern; non-decimal nibbles go dark.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0]       nib_i,
  output logic [SEG_W-1:0] seg_c_o
);

  always_comb begin
    seg_c_o = SEG_BLANK;
    if (nib_i <= 4'd9) begin
      seg_c_o = SEG_LUT[nib_i];
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Snapshots h/m/s, converts them through the shared binary-to-BCD unit one field
// per cycle, then multiplexes the six digits onto the segment bus.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned CNT_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  state_e                state_q, state_d;
  logic [DIG_W-1:0]      dig_q, dig_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIN_W-1:0]      snap_h_q, snap_h_d;
  logic [BIN_W-1:0]      snap_m_q, snap_m_d;
  logic [BIN_W-1:0]      snap_s_q, snap_s_d;
  logic [BCD_W-1:0]      bcd_h_q, bcd_h_d;
  logic [BCD_W-1:0]      bcd_m_q, bcd_m_d;
  logic [BCD_W-1:0]      bcd_s_q, bcd_s_d;
  logic [BIN_W-1:0]      conv_bin_q, conv_bin_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  frame_done_q, frame_done_d;
  logic [3:0]            nib_c;
  logic [SEG_W-1:0]      dec_seg_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SNAP;
      dig_q        <= '0;
      cnt_q        <= '0;
      snap_h_q     <= '0;
      snap_m_q     <= '0;
      snap_s_q     <= '0;
      bcd_h_q      <= '0;
      bcd_m_q      <= '0;
      bcd_s_q      <= '0;
      conv_bin_q   <= '0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dig_q        <= dig_d;
      cnt_q        <= cnt_d;
      snap_h_q     <= snap_h_d;
      snap_m_q     <= snap_m_d;
      snap_s_q     <= snap_s_d;
      bcd_h_q      <= bcd_h_d;
      bcd_m_q      <= bcd_m_d;
      bcd_s_q      <= bcd_s_d;
      conv_bin_q   <= conv_bin_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Sequencing: snapshot, three conversion slots, then the dwell-timed digit scan.
  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    cnt_d      = cnt_q;
    snap_h_d   = snap_h_q;
    snap_m_d   = snap_m_q;
    snap_s_d   = snap_s_q;
    bcd_h_d    = bcd_h_q;
    bcd_m_d    = bcd_m_q;
    bcd_s_d    = bcd_s_q;
    conv_bin_d = conv_bin_q;
    if (bus.en) begin
      unique case (state_q)
        SNAP: begin
          snap_h_d   = bus.hours;
          snap_m_d   = bus.mins;
          snap_s_d   = bus.secs;
          conv_bin_d = bus.secs;  // same value the snapshot captures this edge
          state_d    = CONV_S;
        end
        CONV_S: begin
          bcd_s_d    = bus.conv_bcd;
          conv_bin_d = snap_m_q;
          state_d    = CONV_M;
        end
        CONV_M: begin
          bcd_m_d    = bus.conv_bcd;
          conv_bin_d = snap_h_q;
          state_d    = CONV_H;
        end
        CONV_H: begin
          bcd_h_d = bus.conv_bcd;
          dig_d   = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end
        SCAN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (dig_q == DIG_LAST) begin
              dig_d   = '0;
              state_d = SNAP;
            end else begin
              dig_d = dig_q + DIG_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = SNAP;
      endcase
    end
  end

  // Nibble for the digit that will be lit after this edge.
  always_comb begin
    unique case (dig_d)
      3'd0:    nib_c = bcd_s_q[3:0];
      3'd1:    nib_c = bcd_s_q[7:4];
      3'd2:    nib_c = bcd_m_q[3:0];
      3'd3:    nib_c = bcd_m_q[7:4];
      3'd4:    nib_c = bcd_h_q[3:0];
      3'd5:    nib_c = bcd_h_q[7:4];
      default: nib_c = 4'd0;
    endcase
  end

  seg7_decode u_dec (
    .nib_i   (nib_c),
    .seg_c_o (dec_seg_c)
  );

  // Display outputs follow the next state so anode, segments and digit move together.
  always_comb begin
    an_d         = an_q;
    seg_d        = seg_q;
    frame_done_d = 1'b0;
    if (bus.en) begin
      if (state_d == SCAN) begin
        an_d = ~(NUM_DIGITS'(1) << dig_d);
        if (bus.blank_lz && (dig_d == DIG_LAST) && (nib_c == 4'd0)) begin
          seg_d = SEG_BLANK;
        end else begin
          seg_d = dec_seg_c;
        end
        frame_done_d = (dig_d == DIG_LAST) && (cnt_d == CNT_LAST);
      end else begin
        an_d  = '1;
        seg_d = SEG_BLANK;
      end
    end
  end

  assign bus.conv_bin   = conv_bin_q;
  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a behavioural binary-to-BCD converter attached.
module tb_seg_scan_ctrl;

  localparam int unsigned DWELL = 4;
  localparam int unsigned CNT_W = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_chk  = 0;
  int   dg [6];

  always #5 clk = ~clk;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always_comb bus.conv_bcd = {4'(bus.conv_bin / 6'd10), 4'(bus.conv_bin % 6'd10)};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Hand-written glyph table; 15 stands for a dark digit.
  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_digit(input int d, input logic [6:0] s, input int first_c, input int last_c);
    logic [5:0] an_exp;
    an_exp = ~(6'b000001 << d);
    for (int c = first_c; c <= last_c; c++) begin
      chk($sformatf("an_d%0d_c%0d", d, c), 32'(bus.an), 32'(an_exp));
      chk($sformatf("seg_d%0d_c%0d", d, c), 32'(bus.seg), 32'(s));
      chk($sformatf("fdone_d%0d_c%0d", d, c), 32'(bus.frame_done),
          32'((d == 5) && (c == int'(DWELL) - 1)));
      step();
    end
  endtask

  task automatic scan_digits();
    for (int d = 0; d < 6; d++) check_digit(d, glyph(dg[d]), 0, int'(DWELL) - 1);
  endtask

  // Entered on a SNAP cycle; leaves on the first SCAN cycle.
  task automatic conv_phase(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    chk("snap_an", 32'(bus.an), 32'h3f);
    chk("snap_seg", 32'(bus.seg), 32'h7f);
    step();
    chk("conv_s_bin", 32'(bus.conv_bin), 32'(s));
    chk("conv_s_an", 32'(bus.an), 32'h3f);
    step();
    chk("conv_m_bin", 32'(bus.conv_bin), 32'(m));
    step();
    chk("conv_h_bin", 32'(bus.conv_bin), 32'(h));
    chk("conv_h_seg", 32'(bus.seg), 32'h7f);
    step();
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b1;
    bus.blank_lz = 1'b0;
    bus.hours    = 6'd12;
    bus.mins     = 6'd34;
    bus.secs     = 6'd56;
    repeat (3) step();
    chk("rst_an", 32'(bus.an), 32'h3f);
    chk("rst_seg", 32'(bus.seg), 32'h7f);
    chk("rst_fdone", 32'(bus.frame_done), 32'h0);
    chk("rst_bin", 32'(bus.conv_bin), 32'h0);
    rst = 1'b0;

    // Frame 1: 12:34:56
    chk("snap_bin_zero", 32'(bus.conv_bin), 32'h0);
    conv_phase(6'd12, 6'd34, 6'd56);
    dg = '{6, 5, 4, 3, 2, 1};
    scan_digits();

    // Frame 2: 63:00:09, no clamping
    bus.hours = 6'd63;
    bus.mins  = 6'd0;
    bus.secs  = 6'd9;
    conv_phase(6'd63, 6'd0, 6'd9);
    dg = '{9, 0, 0, 0, 3, 6};
    scan_digits();

    // Frame 3: 05:00:09 with leading-zero blanking
    bus.hours    = 6'd5;
    bus.blank_lz = 1'b1;
    conv_phase(6'd5, 6'd0, 6'd9);
    dg = '{9, 0, 0, 0, 5, 15};
    scan_digits();

    // Frame 4: seconds change mid-scan must not tear the frame
    bus.blank_lz = 1'b0;
    bus.hours    = 6'd12;
    bus.mins     = 6'd34;
    bus.secs     = 6'd10;
    conv_phase(6'd12, 6'd34, 6'd10);
    check_digit(0, glyph(0), 0, 3);
    check_digit(1, glyph(1), 0, 3);
    bus.secs = 6'd11;
    check_digit(2, glyph(4), 0, 3);
    check_digit(3, glyph(3), 0, 3);
    check_digit(4, glyph(2), 0, 3);
    check_digit(5, glyph(1), 0, 3);

    // Frame 5: new seconds visible; enable dropped for 7 cycles during digit 2
    conv_phase(6'd12, 6'd34, 6'd11);
    check_digit(0, glyph(1), 0, 3);
    check_digit(1, glyph(1), 0, 3);
    check_digit(2, glyph(4), 0, 0);
    bus.en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("hold_an_%0d", i), 32'(bus.an), 32'h3b);
      chk($sformatf("hold_seg_%0d", i), 32'(bus.seg), 32'(glyph(4)));
      chk($sformatf("hold_fdone_%0d", i), 32'(bus.frame_done), 32'h0);
    end
    bus.en = 1'b1;
    check_digit(2, glyph(4), 1, 3);
    check_digit(3, glyph(3), 0, 3);
    check_digit(4, glyph(2), 0, 3);
    check_digit(5, glyph(1), 0, 3);

    // Frame 6: reset during digit 3, then a fresh frame
    bus.hours = 6'd7;
    bus.mins  = 6'd8;
    bus.secs  = 6'd9;
    conv_phase(6'd7, 6'd8, 6'd9);
    check_digit(0, glyph(9), 0, 3);
    check_digit(1, glyph(0), 0, 3);
    check_digit(2, glyph(8), 0, 3);
    check_digit(3, glyph(0), 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_an", 32'(bus.an), 32'h3f);
    chk("mid_rst_seg", 32'(bus.seg), 32'h7f);
    chk("mid_rst_bin", 32'(bus.conv_bin), 32'h0);
    chk("mid_rst_fdone", 32'(bus.frame_done), 32'h0);
    bus.hours = 6'd23;
    bus.mins  = 6'd22;
    bus.secs  = 6'd21;
    conv_phase(6'd23, 6'd22, 6'd21);
    dg = '{1, 2, 2, 2, 3, 2};
    scan_digits();
    chk("end_snap_an", 32'(bus.an), 32'h3f);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
